dram_arbiter: RTL and testbench
===============================

// Module: dram_arbiter
// PURPOSE
// - Shares the single-ported data RAM between two requesters: the CPU MEM stage (port C) and the debug/loader port (port D).
// - Sits between the MEM stage and the data RAM. Drives RAM address, data, mode, write enable, chip select and read enable.
// - CPU has priority. Port D is protected from starvation, and port D can hold the RAM for short locked bursts.
// PARAMETERS
// - ADDR_W     12  RAM word/byte address width (low address bits forwarded to RAM)
// - DATA_W     32  data width
// - STARVE_MAX 4   consecutive denied cycles of D before D is forced a grant
// - BURST_MAX  8   max consecutive cycles D may hold the RAM under dbg_lock
// PORTS
// - clk        in  1       system clock
// - rst        in  1       synchronous reset, active-high
// - cpu_req    in  1       C access request (load or store)
// - cpu_we     in  1       C write (1) / read (0)
// - cpu_addr   in  ADDR_W  C address
// - cpu_din    in  DATA_W  C store data
// - cpu_mode   in  2       C access size mode, forwarded unchanged to RAM
// - cpu_gnt    out 1       C access performed this cycle (low while cpu_req = pipeline stall)
// - cpu_rvalid out 1       C read data valid (one cycle after grant)
// - cpu_rdata  out DATA_W  C read data
// - dbg_req, dbg_we, dbg_addr, dbg_din, dbg_mode  in  as C-side equivalents
// - dbg_lock   in  1       D requests to keep ownership on following cycles
// - dbg_gnt, dbg_rvalid, dbg_rdata  out  as C-side equivalents
// - ram_addr   out ADDR_W; ram_din out DATA_W; ram_mode out 2
// - ram_we     out 1       RAM write enable
// - ram_sel    out 1       RAM chip select
// - ram_re     out 1       RAM read enable
// - ram_dout   in  DATA_W  RAM read data, valid combinationally in the access cycle
// BEHAVIOUR
// - Reset: all gnt/rvalid/rdata = 0; state = ARB; starve_cnt = 0; burst_cnt = 0.
// - RAM outputs are combinational from the winner; all are 0 when there is no grant.
// - ram_sel = any grant. ram_we = winner_we. ram_re = grant & ~winner_we.
// - Grants are combinational in the same cycle and are never both high.
// - FSM ARB:
//   - Force D (dbg_gnt) if dbg_req & starve_cnt == STARVE_MAX.
//   - Otherwise cpu_req wins; otherwise dbg_req wins.
//   - If D is granted with dbg_lock=1: next state LOCK, burst_cnt <= 1.
// - FSM LOCK:
//   - D owns the RAM; cpu_gnt = 0. dbg_gnt = dbg_req. burst_cnt increments on each LOCK cycle.
//   - Return to ARB when dbg_lock=0, dbg_req=0, or burst_cnt == BURST_MAX-1 (the final locked cycle).
//   - After exit, C wins the next cycle if it is requesting, even if dbg_lock stays high.
// - starve_cnt:
//   - Increments (saturating at STARVE_MAX) each cycle dbg_req=1 & dbg_gnt=0.
//   - Clears on dbg_gnt or dbg_req=0.
// - Read return: on a read grant, ram_dout is registered into that port's rdata. rvalid is high for exactly the next cycle.
// - rdata holds its last value otherwise. Back-to-back reads give back-to-back rvalid.
// - Writes return no rvalid. Both rvalid are never high together.
// - A loser's request has no side effect. Requesters must hold req/addr/data stable until gnt.
// - Reset mid-LOCK or with a read in flight: the FSM returns to ARB and the pending rvalid is dropped (0 next cycle).
// - Address is forwarded unmodified. Mode/alignment checking belongs to the RAM and is not performed here.
// STRUCTURE
// - Shared package holds:
//   - arbitration state enum {ARB, LOCK}
//   - port index constants PORT_C=0, PORT_D=1
//   - mode encoding constants used by RAM and MEM
// - One natural sub-module, dram_rd_return: captures ram_dout and produces per-port rvalid/rdata from the registered winner index.
// - Grant logic and FSM stay in the top.
// TESTING
// - Reset: rst=1 for 2 cycles with both req high -> all gnt, rvalid and ram_* are 0; after release, cpu_gnt=1 first.
// - Contention: cpu_req and dbg_req held high continuously -> C granted 4 cycles, D on the 5th, repeating. starve_cnt never exceeds 4.
// - Read latency: C reads addr 0x010 holding 0xDEADBEEF -> cpu_gnt in cycle N; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF in N+1 only.
// - Lock burst: D granted with dbg_lock=1, 12 writes -> D owns 8 consecutive cycles, waiting C gets 1 cycle, then D resumes.
// - Write path: D writes 0x12345678 to 0x0FC with mode=2'b00 -> ram_we=1, ram_sel=1, ram_mode=0, ram_re=0; a later C read returns 0x12345678.
// - Reset mid-LOCK after a D read grant -> next cycle dbg_rvalid=0, state ARB, cpu_req wins.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dram_arbiter_pkg
// Shared definitions for the data-RAM arbiter and its read-return block.
//   - arb_state_t   : arbitration FSM state (ARB = normal priority, LOCK = D burst)
//   - PORT_C/PORT_D : port index used to route read data back to its owner
//   - MODE_*        : access size encoding shared by the MEM stage and the RAM
//   - arb_status_t  : observability bundle (FSM state and counters)
// ---------------------------------------------------------------------------
package dram_arbiter_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;

    // Counters are zero-extended into fixed 8-bit fields so the status
    // bundle has one shape regardless of parameterisation.
    typedef struct packed {
        arb_state_t  state;
        logic [7:0]  starve_cnt;
        logic [7:0]  burst_cnt;
    } arb_status_t;

endpackage

// File: rtl/dram_rd_return.sv
// ---------------------------------------------------------------------------
// dram_rd_return
// Captures RAM read data in the access cycle and returns it to the port that
// won the read, with a single-cycle rvalid in the following cycle.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_rd_fire      : a read was granted this cycle
//   i_rd_port      : winner index of that read (PORT_C / PORT_D)
//   i_ram_dout     : RAM read data, valid in the access cycle
//   o_c_rvalid/o_c_rdata : port C read return
//   o_d_rvalid/o_d_rdata : port D read return
// ---------------------------------------------------------------------------
module dram_rd_return
    import dram_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rd_fire,
    input  logic              i_rd_port,
    input  logic [DATA_W-1:0] i_ram_dout,
    output logic              o_c_rvalid,
    output logic [DATA_W-1:0] o_c_rdata,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata
);

    logic              r_pending;
    logic              r_port;
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= 1'b0;
            r_port    <= PORT_C;
            r_c_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_pending <= i_rd_fire;
            if (i_rd_fire) begin
                r_port <= i_rd_port;
                if (i_rd_port == PORT_C) begin
                    r_c_rdata <= i_ram_dout;
                end else begin
                    r_d_rdata <= i_ram_dout;
                end
            end
        end
    end

    // A reset arriving while a read is in flight drops its rvalid at once,
    // not only after the reset edge.
    assign o_c_rvalid = r_pending & ~i_rst & (r_port == PORT_C);
    assign o_d_rvalid = r_pending & ~i_rst & (r_port == PORT_D);
    assign o_c_rdata  = r_c_rdata;
    assign o_d_rdata  = r_d_rdata;

endmodule

// File: rtl/dram_arbiter.sv
// ---------------------------------------------------------------------------
// dram_arbiter
// Shares the single-ported data RAM between the CPU MEM stage (port C) and
// the debug/loader port (port D). C has priority; D is force-granted after
// STARVE_MAX consecutive denied cycles and may hold the RAM for up to
// BURST_MAX cycles while dbg_lock is high.
//
// Handshake (both ports): a requester raises *_req with *_we/addr/din/mode
// stable and keeps them stable until *_gnt is seen high in the same cycle;
// *_gnt high means the access is performed in that cycle. A read's data is
// returned on *_rdata with *_rvalid high for exactly the following cycle.
//
// Ports
//   clk, rst                        : clock, synchronous active-high reset
//   cpu_req/we/addr/din/mode        : port C request
//   cpu_gnt, cpu_rvalid, cpu_rdata  : port C grant and read return
//   dbg_req/we/addr/din/mode        : port D request
//   dbg_lock                        : D asks to keep ownership next cycle
//   dbg_gnt, dbg_rvalid, dbg_rdata  : port D grant and read return
//   ram_addr/din/mode/we/sel/re     : RAM control, driven by the winner
//   ram_dout                        : RAM read data (combinational)
//   o_arb_status                    : FSM state and counters for observation
// ---------------------------------------------------------------------------
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic [1:0]        cpu_mode,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_din,
    input  logic [1:0]        dbg_mode,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic [1:0]        ram_mode,
    output logic              ram_we,
    output logic              ram_sel,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_dout,
    output arb_status_t       o_arb_status
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int BURST_W  = $clog2(BURST_MAX + 1);

    arb_state_t          r_state;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic [BURST_W-1:0]  r_burst_cnt;

    logic w_force_d;
    logic w_gnt_c;
    logic w_gnt_d;
    logic w_rd_fire;
    logic w_rd_port;

    // ---------------------------------------------------------------
    // Grant logic: combinational, same-cycle, one-hot or idle.
    // ---------------------------------------------------------------
    always_comb begin
        w_force_d = dbg_req && (r_starve_cnt == STARVE_W'(STARVE_MAX));
        w_gnt_c   = 1'b0;
        w_gnt_d   = 1'b0;
        if (!rst) begin
            case (r_state)
                ARB: begin
                    if (w_force_d) begin
                        w_gnt_d = 1'b1;
                    end else if (cpu_req) begin
                        w_gnt_c = 1'b1;
                    end else if (dbg_req) begin
                        w_gnt_d = 1'b1;
                    end
                end
                LOCK: begin
                    w_gnt_d = dbg_req;
                end
                default: begin
                    w_gnt_c = 1'b0;
                    w_gnt_d = 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // RAM-side mux: everything forced to zero when nobody is granted.
    // ---------------------------------------------------------------
    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_mode = 2'b00;
        ram_we   = 1'b0;
        if (w_gnt_c) begin
            ram_addr = cpu_addr;
            ram_din  = cpu_din;
            ram_mode = cpu_mode;
            ram_we   = cpu_we;
        end else if (w_gnt_d) begin
            ram_addr = dbg_addr;
            ram_din  = dbg_din;
            ram_mode = dbg_mode;
            ram_we   = dbg_we;
        end
    end

    assign ram_sel   = w_gnt_c | w_gnt_d;
    assign ram_re    = ram_sel & ~ram_we;
    assign cpu_gnt   = w_gnt_c;
    assign dbg_gnt   = w_gnt_d;
    assign w_rd_fire = ram_re;
    assign w_rd_port = w_gnt_d ? PORT_D : PORT_C;

    // ---------------------------------------------------------------
    // Arbitration FSM and its counters.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB;
            r_starve_cnt <= '0;
            r_burst_cnt  <= '0;
        end else begin
            if (!dbg_req || w_gnt_d) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_W'(STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            case (r_state)
                ARB: begin
                    if (w_gnt_d && dbg_lock) begin
                        r_state     <= LOCK;
                        r_burst_cnt <= BURST_W'(1);
                    end else begin
                        r_burst_cnt <= '0;
                    end
                end
                LOCK: begin
                    // Leaving LOCK always lands in ARB, where C (if waiting)
                    // wins because D's grant cleared the starvation count.
                    if (!dbg_lock || !dbg_req ||
                        r_burst_cnt == BURST_W'(BURST_MAX - 1)) begin
                        r_state     <= ARB;
                        r_burst_cnt <= '0;
                    end else begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= ARB;
                    r_burst_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        o_arb_status            = '0;
        o_arb_status.state      = r_state;
        o_arb_status.starve_cnt = 8'(r_starve_cnt);
        o_arb_status.burst_cnt  = 8'(r_burst_cnt);
    end

    dram_rd_return #(
        .DATA_W (DATA_W)
    ) u_rd_return (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rd_fire  (w_rd_fire),
        .i_rd_port  (w_rd_port),
        .i_ram_dout (ram_dout),
        .o_c_rvalid (cpu_rvalid),
        .o_c_rdata  (cpu_rdata),
        .o_d_rvalid (dbg_rvalid),
        .o_d_rdata  (dbg_rdata)
    );

endmodule

// File: tb/tb_dram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dram_arbiter
// Directed bench for dram_arbiter with a small behavioural RAM. Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_dram_arbiter;
    import dram_arbiter_pkg::*;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din, cpu_rdata;
    logic [1:0]        cpu_mode;
    logic              dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_din, dbg_rdata;
    logic [1:0]        dbg_mode;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din, ram_dout;
    logic [1:0]        ram_mode;
    logic              ram_we, ram_sel, ram_re;
    arb_status_t       arb_status;

    dram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4), .BURST_MAX(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_mode(cpu_mode), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_din(dbg_din), .dbg_mode(dbg_mode), .dbg_lock(dbg_lock),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_mode(ram_mode),
        .ram_we(ram_we), .ram_sel(ram_sel), .ram_re(ram_re),
        .ram_dout(ram_dout), .o_arb_status(arb_status)
    );

    // ---------------- behavioural RAM ----------------
    // Known words are (re)loaded while reset is high.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (rst) begin
            mem[12'h010] <= 32'hDEAD_BEEF;
            mem[12'h014] <= 32'h1111_2222;
            mem[12'h020] <= 32'hCAFE_F00D;
        end else if (ram_sel && ram_we) begin
            mem[ram_addr] <= ram_din;
        end
    end
    assign ram_dout = mem[ram_addr];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_mode = MODE_WORD;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_din = '0; dbg_mode = MODE_WORD;
        dbg_lock = 1'b0;
    endtask

    int  d_idx;
    logic c_done;
    logic exp_c, exp_d, prev_c, prev_d;

    initial begin
        idle_inputs();
        rst = 1'b1;

        // ---- reset with both ports requesting reads ----
        cpu_req = 1'b1; cpu_addr = 12'h014;
        dbg_req = 1'b1; dbg_addr = 12'h020;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_ctrl", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, ram_sel, ram_we, ram_re}, '0);
            check("rst_bus", {ram_addr, ram_din, ram_mode}, '0);
            next_cycle();
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst_state", 64'(arb_status.state), 64'(ARB));

        // ---- contention: C four cycles, D on the fifth ----
        prev_c = 1'b0; prev_d = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k != 0) @(negedge clk);
            exp_d = ((k % 5) == 4);
            exp_c = !exp_d;
            check("cont_gnt", {cpu_gnt, dbg_gnt}, {exp_c, exp_d});
            check("cont_starve", 64'(arb_status.starve_cnt), 64'(k % 5));
            check("cont_rvalid", {cpu_rvalid, dbg_rvalid}, {prev_c, prev_d});
            prev_c = exp_c; prev_d = exp_d;
            next_cycle();
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        check("cont_tail_rv", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid}, 4'b0001);
        check("cont_d_rdata", dbg_rdata, 32'hCAFE_F00D);
        check("cont_c_rdata", cpu_rdata, 32'h1111_2222);
        next_cycle();

        // ---- read latency: C reads 0x010 ----
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010; cpu_mode = MODE_WORD;
        @(negedge clk);
        check("rd_gnt", {cpu_gnt, dbg_gnt, ram_sel, ram_re, ram_we}, 5'b10110);
        check("rd_addr", ram_addr, 12'h010);
        check("rd_rvalid_n", cpu_rvalid, 1'b0);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check("rd_rvalid_n1", {cpu_rvalid, dbg_rvalid}, 2'b10);
        check("rd_rdata_n1", cpu_rdata, 32'hDEAD_BEEF);
        next_cycle();
        @(negedge clk);
        check("rd_rvalid_n2", cpu_rvalid, 1'b0);
        check("rd_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
        next_cycle();

        // ---- write path: D writes 0x12345678 to 0x0FC, byte mode ----
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'h0FC; dbg_din = 32'h1234_5678;
        dbg_mode = MODE_BYTE; dbg_lock = 1'b0;
        @(negedge clk);
        check("wr_ctrl", {dbg_gnt, cpu_gnt, ram_we, ram_sel, ram_re}, 5'b10110);
        check("wr_mode", ram_mode, MODE_BYTE);
        check("wr_bus", {ram_addr, ram_din}, {12'h0FC, 32'h1234_5678});
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("wr_no_rvalid", {cpu_rvalid, dbg_rvalid}, 2'b00);
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 12'h0FC; cpu_mode = MODE_WORD;
        @(negedge clk);
        check("wr_rb_gnt", cpu_gnt, 1'b1);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check("wr_rb_data", {cpu_rvalid, cpu_rdata}, {1'b1, 32'h1234_5678});
        next_cycle();

        // ---- lock burst: 12 D writes, C arrives on cycle 2 ----
        d_idx = 0; c_done = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            dbg_req  = (d_idx < 12); dbg_we = 1'b1; dbg_lock = 1'b1; dbg_mode = MODE_WORD;
            dbg_addr = 12'h100 + 12'(d_idx);
            dbg_din  = 32'hA000_0000 + 32'(d_idx);
            cpu_req  = (cyc >= 2) && !c_done; cpu_we = 1'b0; cpu_addr = 12'h010;
            @(negedge clk);
            exp_d = (cyc < 8) || (cyc >= 9 && cyc < 13);
            exp_c = (cyc == 8);
            check("lock_gnt", {cpu_gnt, dbg_gnt}, {exp_c, exp_d});
            if (cyc == 7) begin
                check("lock_last", {64'(arb_status.state), 64'(arb_status.burst_cnt)}, {64'(LOCK), 64'd7});
            end
            if (cyc == 8) check("lock_exit", 64'(arb_status.state), 64'(ARB));
            if (cyc == 9) check("lock_c_rd", {cpu_rvalid, cpu_rdata}, {1'b1, 32'hDEAD_BEEF});
            if (dbg_gnt) d_idx++;
            if (cpu_gnt) c_done = 1'b1;
            next_cycle();
        end
        check("lock_done", 64'(d_idx), 64'd12);
        idle_inputs();
        dbg_req = 1'b1; dbg_addr = 12'h10B;
        @(negedge clk);
        check("lock_rb_gnt", dbg_gnt, 1'b1);
        next_cycle();
        dbg_req = 1'b0;
        @(negedge clk);
        check("lock_rb_data", {dbg_rvalid, dbg_rdata}, {1'b1, 32'hA000_000B});
        next_cycle();

        // ---- reset in the middle of a locked D read ----
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_lock = 1'b1; dbg_addr = 12'h020;
        @(negedge clk);
        check("rl_gnt0", dbg_gnt, 1'b1);
        next_cycle();
        @(negedge clk);
        check("rl_gnt1", {dbg_gnt, 64'(arb_status.state)}, {1'b1, 64'(LOCK)});
        next_cycle();
        rst = 1'b1; cpu_req = 1'b1; cpu_addr = 12'h010;
        @(negedge clk);
        check("rl_rst_cyc", {cpu_gnt, dbg_gnt, dbg_rvalid, cpu_rvalid}, 4'b0000);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rl_state", 64'(arb_status.state), 64'(ARB));
        check("rl_gnt", {cpu_gnt, dbg_gnt, dbg_rvalid}, 3'b100);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("rl_c_rd", {cpu_rvalid, cpu_rdata}, {1'b1, 32'hDEAD_BEEF});
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
